rf_wb_arbiter: RTL and testbench

//   Shares the single register-file write port between two writeback requesters (ALU, LSU)
//   and tracks pending writes per register. Sits between execute/memory stages and reg_file;

---
 rtl/rf_pkg.sv | 18 +
 rtl/rr_arb2.sv | 46 ++++
 rtl/rf_wb_arbiter.sv | 125 ++++++++++++
 tb/tb_rf_wb_arbiter.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared definitions for the register-file writeback arbiter slice.
package rf_pkg;

  localparam int XLEN_DEF = 32;
  localparam int AW_DEF   = 5;

  // Writeback requesters sharing the single reg_file write port.
  typedef enum logic {
    REQ_ALU = 1'b0,
    REQ_LSU = 1'b1
  } req_e;

  // True when a register index names a real (non-x0) register.
  function automatic logic is_real_reg(input logic [AW_DEF-1:0] r);
    return (r != '0);
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-input writeback arbiter: round-robin between ALU and LSU, or LSU-always-wins
// when FIXED_PRIO is nonzero. Holds last_grant, which only moves on a real grant.
module rr_arb2
  import rf_pkg::*;
#(
  parameter int FIXED_PRIO = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic req_alu,
  input  logic req_lsu,
  output logic gnt_alu,
  output logic gnt_lsu
);

  req_e last_grant;

  // Combinational grant: a lone requester always wins; on contention the
  // fixed-priority build favours LSU, otherwise whoever was not granted last.
  always_comb begin
    gnt_alu = 1'b0;
    gnt_lsu = 1'b0;
    if (req_alu && req_lsu) begin
      if ((FIXED_PRIO != 0) || (last_grant == REQ_ALU)) begin
        gnt_lsu = 1'b1;
      end else begin
        gnt_alu = 1'b1;
      end
    end else begin
      gnt_alu = req_alu;
      gnt_lsu = req_lsu;
    end
  end

  // Remember the most recent winner; reset to LSU so ALU wins the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= REQ_LSU;
    end else if (gnt_alu) begin
      last_grant <= REQ_ALU;
    end else if (gnt_lsu) begin
      last_grant <= REQ_LSU;
    end
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file writeback arbiter: shares the single reg_file write port between
// ALU and LSU, registers the winning write, and keeps a per-register pending-write
// scoreboard that stalls issue on RAW/WAW hazards.
module rf_wb_arbiter
  import rf_pkg::*;
#(
  parameter int XLEN       = XLEN_DEF,
  parameter int AW         = AW_DEF,
  parameter int FIXED_PRIO = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            alu_valid,
  input  logic [AW-1:0]   alu_rd,
  input  logic [XLEN-1:0] alu_data,
  output logic            alu_ready,
  input  logic            lsu_valid,
  input  logic [AW-1:0]   lsu_rd,
  input  logic [XLEN-1:0] lsu_data,
  output logic            lsu_ready,
  input  logic            issue_valid,
  input  logic            issue_we,
  input  logic [AW-1:0]   issue_rd,
  input  logic [AW-1:0]   issue_rs0,
  input  logic [AW-1:0]   issue_rs1,
  output logic            issue_stall,
  output logic            rf_we,
  output logic [AW-1:0]   rf_waddr,
  output logic [XLEN-1:0] rf_wdata,
  output logic            err_wb
);

  localparam int NREG = 2 ** AW;

  logic            gnt_alu;
  logic            gnt_lsu;
  logic            grant;
  logic [AW-1:0]   gnt_rd;
  logic [XLEN-1:0] gnt_data;
  logic            wr_real;
  logic            issue_fire;

  // x0 has no scoreboard bit; busy_full pads it with a constant 0 so any
  // register index can be looked up directly.
  logic [NREG-1:1] busy;
  logic [NREG-1:1] busy_nxt;
  logic [NREG-1:0] busy_full;

  rr_arb2 #(
    .FIXED_PRIO (FIXED_PRIO)
  ) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req_alu (alu_valid),
    .req_lsu (lsu_valid),
    .gnt_alu (gnt_alu),
    .gnt_lsu (gnt_lsu)
  );

  assign alu_ready = gnt_alu;
  assign lsu_ready = gnt_lsu;
  assign grant     = gnt_alu | gnt_lsu;
  assign gnt_rd    = gnt_lsu ? lsu_rd   : alu_rd;
  assign gnt_data  = gnt_lsu ? lsu_data : alu_data;

  // A grant to x0 completes the handshake but never reaches reg_file.
  assign wr_real   = grant && (gnt_rd != '0);

  assign busy_full = {busy, 1'b0};

  assign issue_stall = issue_valid &&
                       (busy_full[issue_rs0] || busy_full[issue_rs1] ||
                        (issue_we && busy_full[issue_rd]));

  assign issue_fire  = issue_valid && !issue_stall && issue_we && (issue_rd != '0);

  // Output stage: the granted write appears on the reg_file port one cycle later.
  // Address/data hold their last real write while rf_we is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else begin
      rf_we <= wr_real;
      if (wr_real) begin
        rf_waddr <= gnt_rd;
        rf_wdata <= gnt_data;
      end
    end
  end

  // Scoreboard next state: clear on the edge reg_file is written, set on issue.
  // Set needs the register idle, so a set and a clear never hit the same bit.
  always_comb begin
    busy_nxt = busy;
    for (int r = 1; r < NREG; r++) begin
      if (rf_we && (rf_waddr == AW'(r))) begin
        busy_nxt[r] = 1'b0;
      end
      if (issue_fire && (issue_rd == AW'(r))) begin
        busy_nxt[r] = 1'b1;
      end
    end
  end

  // Scoreboard register.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= '0;
    end else begin
      busy <= busy_nxt;
    end
  end

  // Sticky error: a real writeback landed on a register nobody was waiting on.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_wb <= 1'b0;
    end else if (wr_real && !busy_full[gnt_rd]) begin
      err_wb <= 1'b1;
    end
  end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: a table of per-cycle vectors (inputs,
// expected combinational outputs, expected registered outputs one cycle later)
// plus a hand-written contention/scoreboard sequence. Registered expectations go
// through a queue: pushed when the cycle is driven, popped after the clock edge.
module tb_rf_wb_arbiter;

  localparam int XLEN = 32;
  localparam int AW   = 5;

  logic            clk = 1'b0;
  logic            rst;
  logic            alu_valid;
  logic [AW-1:0]   alu_rd;
  logic [XLEN-1:0] alu_data;
  logic            lsu_valid;
  logic [AW-1:0]   lsu_rd;
  logic [XLEN-1:0] lsu_data;
  logic            issue_valid;
  logic            issue_we;
  logic [AW-1:0]   issue_rd;
  logic [AW-1:0]   issue_rs0;
  logic [AW-1:0]   issue_rs1;

  logic            alu_ready, lsu_ready, issue_stall, rf_we, err_wb;
  logic [AW-1:0]   rf_waddr;
  logic [XLEN-1:0] rf_wdata;

  logic            fp_alu_ready, fp_lsu_ready, fp_issue_stall, fp_rf_we, fp_err_wb;
  logic [AW-1:0]   fp_rf_waddr;
  logic [XLEN-1:0] fp_rf_wdata;

  always #5 clk = ~clk;

  rf_wb_arbiter #(.XLEN(XLEN), .AW(AW), .FIXED_PRIO(0)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data), .lsu_ready(lsu_ready),
    .issue_valid(issue_valid), .issue_we(issue_we), .issue_rd(issue_rd),
    .issue_rs0(issue_rs0), .issue_rs1(issue_rs1), .issue_stall(issue_stall),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .err_wb(err_wb)
  );

  rf_wb_arbiter #(.XLEN(XLEN), .AW(AW), .FIXED_PRIO(1)) dut_fp (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(fp_alu_ready),
    .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data), .lsu_ready(fp_lsu_ready),
    .issue_valid(issue_valid), .issue_we(issue_we), .issue_rd(issue_rd),
    .issue_rs0(issue_rs0), .issue_rs1(issue_rs1), .issue_stall(fp_issue_stall),
    .rf_we(fp_rf_we), .rf_waddr(fp_rf_waddr), .rf_wdata(fp_rf_wdata), .err_wb(fp_err_wb)
  );

  typedef struct {
    int rst;
    int av; int ard; int ad;
    int lv; int lrd; int ld;
    int iv; int iwe; int ird; int rs0; int rs1;
    int cc;                        // check combinational outputs this cycle
    int ar; int lr; int st; int far; int flr;
    int ewe; int ewa; int ewd; int eerr; int cad;
  } vec_t;

  typedef struct {
    int we; int waddr; int wdata; int err; int cad;
  } exp_t;

  vec_t vq[$];
  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic pop_cmp(input string tag);
    exp_t e;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: scoreboard empty, got rf_we %0b expected an entry", tag, rf_we);
    end else begin
      e = exp_q.pop_front();
      chk({tag, " rf_we"}, 32'(rf_we), e.we);
      if (e.cad != 0) begin
        chk({tag, " rf_waddr"}, 32'(rf_waddr), e.waddr);
        chk({tag, " rf_wdata"}, rf_wdata, e.wdata);
      end
      chk({tag, " err_wb"}, 32'(err_wb), e.err);
    end
  endtask

  task automatic set_idle();
    rst = 1'b0;
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    lsu_valid = 1'b0; lsu_rd = '0; lsu_data = '0;
    issue_valid = 1'b0; issue_we = 1'b0; issue_rd = '0; issue_rs0 = '0; issue_rs1 = '0;
  endtask

  task automatic apply(input vec_t v, input int idx);
    string tag;
    exp_t  e;
    tag = $sformatf("v%0d", idx);
    rst         = v.rst[0];
    alu_valid   = v.av[0];  alu_rd = v.ard[AW-1:0]; alu_data = v.ad;
    lsu_valid   = v.lv[0];  lsu_rd = v.lrd[AW-1:0]; lsu_data = v.ld;
    issue_valid = v.iv[0];  issue_we = v.iwe[0];    issue_rd = v.ird[AW-1:0];
    issue_rs0   = v.rs0[AW-1:0];
    issue_rs1   = v.rs1[AW-1:0];
    @(negedge clk);
    if (v.cc != 0) begin
      chk({tag, " alu_ready"},    32'(alu_ready),    v.ar);
      chk({tag, " lsu_ready"},    32'(lsu_ready),    v.lr);
      chk({tag, " issue_stall"},  32'(issue_stall),  v.st);
      chk({tag, " fp alu_ready"}, 32'(fp_alu_ready), v.far);
      chk({tag, " fp lsu_ready"}, 32'(fp_lsu_ready), v.flr);
    end
    e = '{we: v.ewe, waddr: v.ewa, wdata: v.ewd, err: v.eerr, cad: v.cad};
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    pop_cmp(tag);
  endtask

  task automatic hstep(input string nm, input int est, input exp_t e);
    @(negedge clk);
    chk({nm, " issue_stall"}, 32'(issue_stall), est);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    pop_cmp(nm);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish");
    $fatal(1);
  end

  initial begin
    exp_t idle_e;
    exp_t e;
    int   cyc;
    int   alu_cyc;
    int   lsu_cyc;
    idle_e = '{we: 0, waddr: 0, wdata: 0, err: 0, cad: 0};

    //            rst av ard ad     lv lrd ld     iv iwe ird rs0 rs1  cc ar lr st far flr  ewe ewa ewd    eerr cad
    // reset
    vq.push_back('{1, 0, 0, 0,      0, 0, 0,      0, 0, 0, 0, 0,      0, 0, 0, 0, 0, 0,     0, 0, 0,      0, 1});
    // issue rd=5, then ALU writeback rd=5 data 0x11, then RAW on x5
    vq.push_back('{0, 0, 0, 0,      0, 0, 0,      1, 1, 5, 0, 0,      1, 0, 0, 0, 0, 0,     0, 0, 0,      0, 0});
    vq.push_back('{0, 1, 5, 'h11,   0, 0, 0,      0, 0, 0, 0, 0,      1, 1, 0, 0, 1, 0,     1, 5, 'h11,   0, 1});
    vq.push_back('{0, 0, 0, 0,      0, 0, 0,      1, 0, 0, 5, 0,      1, 0, 0, 1, 0, 0,     0, 5, 'h11,   0, 1});
    vq.push_back('{0, 0, 0, 0,      0, 0, 0,      1, 0, 0, 5, 0,      1, 0, 0, 0, 0, 0,     0, 5, 'h11,   0, 1});
    // contention: reset, mark x1/x2 busy, both requesters held 3 cycles
    vq.push_back('{1, 0, 0, 0,      0, 0, 0,      0, 0, 0, 0, 0,      0, 0, 0, 0, 0, 0,     0, 0, 0,      0, 1});
    vq.push_back('{0, 0, 0, 0,      0, 0, 0,      1, 1, 1, 0, 0,      1, 0, 0, 0, 0, 0,     0, 0, 0,      0, 0});
    vq.push_back('{0, 0, 0, 0,      0, 0, 0,      1, 1, 2, 0, 0,      1, 0, 0, 0, 0, 0,     0, 0, 0,      0, 0});
    vq.push_back('{0, 1, 1, 'hA1,   1, 2, 'hB2,   0, 0, 0, 0, 0,      1, 1, 0, 0, 0, 1,     1, 1, 'hA1,   0, 1});
    vq.push_back('{0, 1, 1, 'hA1,   1, 2, 'hB2,   0, 0, 0, 0, 0,      1, 0, 1, 0, 0, 1,     1, 2, 'hB2,   0, 1});
    // third ALU write to x1 finds it no longer busy -> err_wb
    vq.push_back('{0, 1, 1, 'hA1,   1, 2, 'hB2,   0, 0, 0, 0, 0,      1, 1, 0, 0, 0, 1,     1, 1, 'hA1,   1, 1});
    vq.push_back('{0, 0, 0, 0,      0, 0, 0,      0, 0, 0, 0, 0,      1, 0, 0, 0, 0, 0,     0, 1, 'hA1,   1, 1});
    vq.push_back('{1, 0, 0, 0,      0, 0, 0,      0, 0, 0, 0, 0,      0, 0, 0, 0, 0, 0,     0, 0, 0,      0, 1});
    // RAW on x7: stall until the cycle after rf_we with waddr=7
    vq.push_back('{0, 0, 0, 0,      0, 0, 0,      1, 1, 7, 0, 0,      1, 0, 0, 0, 0, 0,     0, 0, 0,      0, 1});
    vq.push_back('{0, 0, 0, 0,      0, 0, 0,      1, 0, 0, 7, 0,      1, 0, 0, 1, 0, 0,     0, 0, 0,      0, 1});
    vq.push_back('{0, 1, 7, 'h77,   0, 0, 0,      1, 0, 0, 7, 0,      1, 1, 0, 1, 1, 0,     1, 7, 'h77,   0, 1});
    vq.push_back('{0, 0, 0, 0,      0, 0, 0,      1, 0, 0, 7, 0,      1, 0, 0, 1, 0, 0,     0, 7, 'h77,   0, 1});
    vq.push_back('{0, 0, 0, 0,      0, 0, 0,      1, 0, 0, 7, 0,      1, 0, 0, 0, 0, 0,     0, 7, 'h77,   0, 1});
    // x0: never busy, LSU write to x0 handshakes without rf_we
    vq.push_back('{0, 0, 0, 0,      0, 0, 0,      1, 1, 0, 0, 0,      1, 0, 0, 0, 0, 0,     0, 0, 0,      0, 0});
    vq.push_back('{0, 0, 0, 0,      0, 0, 0,      1, 0, 0, 0, 0,      1, 0, 0, 0, 0, 0,     0, 0, 0,      0, 0});
    vq.push_back('{0, 0, 0, 0,      1, 0, 'h55,   0, 0, 0, 0, 0,      1, 0, 1, 0, 0, 1,     0, 0, 0,      0, 0});
    // WAW on x4
    vq.push_back('{0, 0, 0, 0,      0, 0, 0,      1, 1, 4, 0, 0,      1, 0, 0, 0, 0, 0,     0, 0, 0,      0, 0});
    vq.push_back('{0, 0, 0, 0,      0, 0, 0,      1, 1, 4, 0, 0,      1, 0, 0, 1, 0, 0,     0, 0, 0,      0, 0});
    // reset with a pending ALU grant to busy x3
    vq.push_back('{0, 0, 0, 0,      0, 0, 0,      1, 1, 3, 0, 0,      1, 0, 0, 0, 0, 0,     0, 0, 0,      0, 0});
    vq.push_back('{1, 1, 3, 'h33,   0, 0, 0,      0, 0, 0, 0, 0,      0, 0, 0, 0, 0, 0,     0, 0, 0,      0, 1});
    vq.push_back('{0, 0, 0, 0,      0, 0, 0,      1, 0, 0, 3, 0,      1, 0, 0, 0, 0, 0,     0, 0, 0,      0, 1});
    // write to idle x9: performed, err_wb sticky until reset
    vq.push_back('{0, 1, 9, 'h99,   0, 0, 0,      0, 0, 0, 0, 0,      1, 1, 0, 0, 1, 0,     1, 9, 'h99,   1, 1});
    vq.push_back('{0, 0, 0, 0,      0, 0, 0,      0, 0, 0, 0, 0,      1, 0, 0, 0, 0, 0,     0, 9, 'h99,   1, 1});
    vq.push_back('{0, 0, 0, 0,      0, 0, 0,      0, 0, 0, 0, 0,      1, 0, 0, 0, 0, 0,     0, 9, 'h99,   1, 1});
    vq.push_back('{1, 0, 0, 0,      0, 0, 0,      0, 0, 0, 0, 0,      0, 0, 0, 0, 0, 0,     0, 0, 0,      0, 1});

    set_idle();
    foreach (vq[i]) apply(vq[i], i);

    // Hand sequence: both requesters held until accepted after reset (ALU first),
    // then a set of x12 on the same edge that clears x10.
    set_idle();
    issue_valid = 1'b1; issue_we = 1'b1; issue_rd = 5'd10;
    hstep("h_iss10", 0, idle_e);
    issue_rd = 5'd11;
    hstep("h_iss11", 0, idle_e);

    set_idle();
    alu_valid = 1'b1; alu_rd = 5'd11; alu_data = 32'hCC;
    lsu_valid = 1'b1; lsu_rd = 5'd10; lsu_data = 32'hDD;
    cyc = 0; alu_cyc = -1; lsu_cyc = -1;
    while ((alu_valid || lsu_valid) && cyc < 6) begin
      @(negedge clk);
      chk($sformatf("h_c%0d single_grant", cyc), 32'(alu_ready && lsu_ready), 0);
      if (alu_ready) begin
        alu_cyc = cyc;
        e = '{we: 1, waddr: 11, wdata: 'hCC, err: 0, cad: 1};
      end else if (lsu_ready) begin
        lsu_cyc = cyc;
        e = '{we: 1, waddr: 10, wdata: 'hDD, err: 0, cad: 1};
      end else begin
        e = idle_e;
      end
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      pop_cmp($sformatf("h_c%0d", cyc));
      if (alu_cyc == cyc) alu_valid = 1'b0;
      if (lsu_cyc == cyc) lsu_valid = 1'b0;
      cyc++;
    end
    chk("h_alu_grant_cycle", 32'(alu_cyc), 0);
    chk("h_lsu_grant_cycle", 32'(lsu_cyc), 1);

    set_idle();
    issue_valid = 1'b1; issue_we = 1'b1; issue_rd = 5'd12; issue_rs0 = 5'd11;
    hstep("h_setclr", 0, idle_e);
    set_idle();
    issue_valid = 1'b1; issue_rs0 = 5'd10;
    hstep("h_x10_clear", 0, idle_e);
    issue_rs0 = 5'd12;
    hstep("h_x12_set", 1, idle_e);
    set_idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
